// File: rtl/rv0_core_pkg.sv
// Shared core-wide constants and the fetch-to-decode buffer entry.
package rv0_core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]     insn;
        logic [XLEN-1:0] addr;
    } sbuf_entry_t;
endpackage

// File: rtl/rv_sbuf_if.sv
// Ready/ack handshake carrying one fetched instruction and its address.
interface rv_sbuf_if;
    import rv0_core_pkg::*;
    logic [31:0]     insn;
    logic [XLEN-1:0] addr;
    logic            rdy;
    logic            ack;

    modport source (output insn, output addr, output rdy, input ack);
    modport sink   (input insn, input addr, input rdy, output ack);
endinterface

// File: rtl/rv0_fifo.sv
// Synchronous FIFO with clear; push while full is accepted when a pop happens the same cycle.
module rv0_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o
);
    localparam int AW1 = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             full, empty, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == AW1'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            cnt_q <= cnt_q + AW1'(do_push) - AW1'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/rv0_ifu.sv
// Instruction fetch unit: credit-limited word fetch into a small buffer, with redirect
// that drains stale in-flight responses through a discard counter.
module rv0_ifu #(
    parameter int              XLEN       = rv0_core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_ADDR = rv0_core_pkg::RESET_ADDR,
    parameter int              DEPTH      = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ifu_flush_i,
    input  logic [XLEN-1:0] ifu_flush_addr_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    rv_sbuf_if.source       ifu_sbuf_if
);
    import rv0_core_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam int UW = CW + 1;
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   disc_q, disc_d;
    logic [AW:0]     buf_cnt, aq_cnt;
    logic [XLEN-1:0] aq_head;
    sbuf_entry_t     buf_wdata, buf_head;
    logic [UW-1:0]   used;
    logic            fire, resp_keep, buf_pop, rdy;

    // Discarded responses still occupy credit so the buffer can never overflow.
    assign used       = UW'(buf_cnt) + UW'(aq_cnt) + UW'(disc_q);
    assign imem_req_o = rst_ni && !ifu_flush_i && (used < UW'(DEPTH));
    assign imem_addr_o = pc_q;
    assign fire       = imem_req_o && imem_gnt_i;
    assign resp_keep  = imem_rvalid_i && (disc_q == '0) && !ifu_flush_i;
    assign rdy        = (buf_cnt != '0);
    assign buf_pop    = rdy && ifu_sbuf_if.ack && !ifu_flush_i;

    assign buf_wdata.insn = imem_rdata_i;
    assign buf_wdata.addr = aq_head;

    assign ifu_sbuf_if.rdy  = rdy;
    assign ifu_sbuf_if.insn = rdy ? buf_head.insn : '0;
    assign ifu_sbuf_if.addr = rdy ? buf_head.addr : '0;

    always_comb begin
        pc_d   = pc_q;
        disc_d = disc_q;
        if (ifu_flush_i) begin
            pc_d = ifu_flush_addr_i & ALIGN;
            // Everything in flight, plus a grant landing this cycle, becomes stale.
            disc_d = disc_q + CW'(aq_cnt) + CW'(imem_gnt_i) - CW'(imem_rvalid_i);
        end else begin
            if (fire) pc_d = pc_q + XLEN'(4);
            if (imem_rvalid_i && disc_q != '0) disc_d = disc_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_ADDR & ALIGN;
            disc_q <= '0;
        end else begin
            pc_q   <= pc_d;
            disc_q <= disc_d;
        end
    end

    rv0_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (ifu_flush_i),
        .push_i  (fire),
        .wdata_i (pc_q),
        .pop_i   (resp_keep),
        .rdata_o (aq_head),
        .count_o (aq_cnt)
    );

    rv0_fifo #(.WIDTH($bits(sbuf_entry_t)), .DEPTH(DEPTH)) u_ibuf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (ifu_flush_i),
        .push_i  (resp_keep),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .rdata_o (buf_head),
        .count_o (buf_cnt)
    );

`ifndef SYNTHESIS
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (aq_cnt != '0 || disc_q != '0));
`endif
endmodule

// File: tb/tb_rv0_ifu.sv
// Directed bench for rv0_ifu with a simple in-order memory model.
module tb_rv0_ifu;
    logic        clk, rst_n;
    logic        flush;
    logic [31:0] flush_addr;
    logic        req, gnt, rvalid;
    logic [31:0] addr, rdata;
    logic        hold_resp;
    int          n_acc;
    int          nchk, nerr;
    logic [31:0] pend[$];

    rv_sbuf_if sbuf();

    rv0_ifu #(.XLEN(32), .RESET_ADDR(32'h0), .DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .ifu_flush_i      (flush),
        .ifu_flush_addr_i (flush_addr),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_gnt_i       (gnt),
        .imem_rvalid_i    (rvalid),
        .imem_rdata_i     (rdata),
        .ifu_sbuf_if      (sbuf)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory: accepts on gnt, returns in order; zero-wait unless hold_resp.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            n_acc  <= 0;
            pend.delete();
        end else begin
            if (gnt && (req || flush)) begin
                pend.push_back(addr);
                n_acc <= n_acc + 1;
            end
            if (!hold_resp && pend.size() > 0) begin
                rvalid <= 1'b1;
                rdata  <= f(pend.pop_front());
            end else begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic do_reset();
        flush = 0; gnt = 1; sbuf.ack = 0; hold_resp = 0; flush_addr = '0;
        @(negedge clk);
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        flush = 0; gnt = 1; sbuf.ack = 0; hold_resp = 0; flush_addr = '0;
        rst_n = 0;
        #12;
        nchk++; if (req !== 1'b0) begin nerr++; $display("FAIL reset_req: got %b exp 0", req); end
        nchk++; if (sbuf.rdy !== 1'b0) begin nerr++; $display("FAIL reset_rdy: got %b exp 0", sbuf.rdy); end
        nchk++; if (sbuf.insn !== 32'h0) begin nerr++; $display("FAIL reset_insn: got %h exp 0", sbuf.insn); end
        nchk++; if (sbuf.addr !== 32'h0) begin nerr++; $display("FAIL reset_addr: got %h exp 0", sbuf.addr); end
        @(negedge clk);
        rst_n = 1;
        #1;
        nchk++; if ({req, addr} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL reset_first_req: got %b/%h exp 1/0", req, addr); end
    endtask

    task automatic test_stream();
        do_reset();
        sbuf.ack = 1;
        @(negedge clk);
        nchk++; if (sbuf.rdy !== 1'b0) begin nerr++; $display("FAIL stream_latency: rdy %b exp 0", sbuf.rdy); end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            nchk++;
            if ({sbuf.rdy, sbuf.addr, sbuf.insn} !== {1'b1, 32'(4*i), f(32'(4*i))}) begin
                nerr++;
                $display("FAIL stream_%0d: got rdy %b addr %h insn %h exp 1 %h %h", i, sbuf.rdy, sbuf.addr, sbuf.insn, 32'(4*i), f(32'(4*i)));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) @(negedge clk);
        nchk++; if (n_acc !== 4) begin nerr++; $display("FAIL bp_grants: got %0d exp 4", n_acc); end
        nchk++; if (req !== 1'b0) begin nerr++; $display("FAIL bp_req_drop: got %b exp 0", req); end
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if ({sbuf.rdy, sbuf.addr} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL bp_hold_%0d: got %b/%h exp 1/0", i, sbuf.rdy, sbuf.addr); end
            @(negedge clk);
        end
        sbuf.ack = 1;
        @(negedge clk);
        nchk++; if (sbuf.addr !== 32'h4) begin nerr++; $display("FAIL bp_next_head: got %h exp 4", sbuf.addr); end
        nchk++; if ({req, addr} !== {1'b1, 32'h10}) begin nerr++; $display("FAIL bp_resume: got %b/%h exp 1/10", req, addr); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        gnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nchk++;
            if ({req, addr, n_acc} !== {1'b1, 32'h0, 32'd0}) begin
                nerr++; $display("FAIL stall_%0d: got req %b addr %h acc %0d exp 1 0 0", i, req, addr, n_acc);
            end
        end
        gnt = 1;
        @(negedge clk);
        nchk++; if ({addr, n_acc} !== {32'h4, 32'd1}) begin nerr++; $display("FAIL stall_release: got %h/%0d exp 4/1", addr, n_acc); end
    endtask

    task automatic test_flush();
        int k;
        do_reset();
        hold_resp = 1;
        repeat (2) @(negedge clk);
        nchk++; if (n_acc !== 2) begin nerr++; $display("FAIL flush_outstanding: got %0d exp 2", n_acc); end
        gnt = 0; flush = 1; flush_addr = 32'h8000_0002;
        #1;
        nchk++; if (req !== 1'b0) begin nerr++; $display("FAIL flush_req_low: got %b exp 0", req); end
        @(negedge clk);
        flush = 0; hold_resp = 0; gnt = 1;
        #1;
        nchk++; if ({req, addr, sbuf.rdy} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            nerr++; $display("FAIL flush_redirect: got req %b addr %h rdy %b exp 1 80000000 0", req, addr, sbuf.rdy);
        end
        k = 0;
        while (!sbuf.rdy && k < 12) begin @(negedge clk); k++; end
        nchk++;
        if ({sbuf.rdy, sbuf.addr, sbuf.insn} !== {1'b1, 32'h8000_0000, f(32'h8000_0000)}) begin
            nerr++; $display("FAIL flush_first_rdy: got %b %h %h exp 1 80000000 %h", sbuf.rdy, sbuf.addr, sbuf.insn, f(32'h8000_0000));
        end
    endtask

    task automatic test_flush_ack_gnt();
        int k;
        do_reset();
        sbuf.ack = 1;
        repeat (5) @(negedge clk);
        nchk++; if (sbuf.rdy !== 1'b1) begin nerr++; $display("FAIL fag_streaming: rdy %b exp 1", sbuf.rdy); end
        flush = 1; flush_addr = 32'h0000_0100;
        @(negedge clk);
        flush = 0;
        #1;
        nchk++; if ({sbuf.rdy, addr} !== {1'b0, 32'h100}) begin nerr++; $display("FAIL fag_after: got rdy %b addr %h exp 0 100", sbuf.rdy, addr); end
        k = 0;
        while (!sbuf.rdy && k < 12) begin @(negedge clk); k++; end
        nchk++;
        if ({sbuf.rdy, sbuf.addr, sbuf.insn} !== {1'b1, 32'h100, f(32'h100)}) begin
            nerr++; $display("FAIL fag_first: got %b %h %h exp 1 100 %h", sbuf.rdy, sbuf.addr, sbuf.insn, f(32'h100));
        end
        @(negedge clk);
        nchk++; if (sbuf.addr !== 32'h104) begin nerr++; $display("FAIL fag_second: got %h exp 104", sbuf.addr); end
    endtask

    task automatic test_wrap_reset();
        int k;
        do_reset();
        sbuf.ack = 1;
        @(negedge clk);
        flush = 1; flush_addr = 32'hFFFF_FFF8;
        @(negedge clk);
        flush = 0;
        #1;
        nchk++; if (addr !== 32'hFFFF_FFF8) begin nerr++; $display("FAIL wrap_a: got %h exp fffffff8", addr); end
        @(negedge clk);
        nchk++; if (addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_b: got %h exp fffffffc", addr); end
        @(negedge clk);
        nchk++; if (addr !== 32'h0) begin nerr++; $display("FAIL wrap_c: got %h exp 0", addr); end
        repeat (2) @(negedge clk);
        nchk++; if (sbuf.rdy !== 1'b1) begin nerr++; $display("FAIL midburst_busy: rdy %b exp 1", sbuf.rdy); end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        nchk++;
        if ({req, sbuf.rdy, sbuf.insn, sbuf.addr} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            nerr++; $display("FAIL async_reset: got req %b rdy %b insn %h addr %h exp all 0", req, sbuf.rdy, sbuf.insn, sbuf.addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        nchk++; if ({req, addr} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL refetch_req: got %b/%h exp 1/0", req, addr); end
        k = 0;
        while (!sbuf.rdy && k < 12) begin @(negedge clk); k++; end
        nchk++;
        if ({sbuf.rdy, sbuf.addr, sbuf.insn} !== {1'b1, 32'h0, f(32'h0)}) begin
            nerr++; $display("FAIL refetch_first: got %b %h %h exp 1 0 %h", sbuf.rdy, sbuf.addr, sbuf.insn, f(32'h0));
        end
    endtask

    initial begin
        nchk = 0; nerr = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_flush();
        test_flush_ack_gnt();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv0_ifu.md
RV0_IFU -- requirements
Module: rv0_ifu

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have parameter DEPTH, default 4, fetch buffer entries (power of two, >=2).
REQ-004 SHALL have port clk_i  input  1  single core clock.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ifu_flush_i  input  1  redirect fetch, discard buffered/in-flight data.
REQ-007 SHALL have port ifu_flush_addr_i  input  XLEN  redirect target.
REQ-008 SHALL have port imem_req_o  output  1  memory read request.
REQ-009 SHALL have port imem_addr_o  output  XLEN  request address, word aligned.
REQ-010 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-011 SHALL have port imem_rvalid_i  input  1  read data valid; in-order, >=1 cycle after gnt.
REQ-012 SHALL have port imem_rdata_i  input  32  instruction word.
REQ-013 SHALL have port ifu_sbuf_if  rv_sbuf_if.source  -  drives insn (32), addr (XLEN), rdy; samples ack.

Function
REQ-014 SHALL hold fetch PC; imem_addr_o = PC with bits [1:0] forced to 0.
REQ-015 SHALL assert imem_req_o when credit = DEPTH - buffered - outstanding > 0 and ifu_flush_i low.
REQ-016 SHALL keep imem_addr_o stable while imem_req_o high and imem_gnt_i low.
REQ-017 SHALL on req&&gnt advance PC by 4 (wrap modulo 2^XLEN) and push PC onto address queue; outstanding +1.
REQ-018 SHALL on imem_rvalid_i pop address queue, write {rdata, addr} into buffer; outstanding -1.
REQ-019 SHALL drive rdy = buffer not empty; insn/addr = head entry, stable while rdy && !ack.
REQ-020 SHALL pop head when rdy && ack; ack with rdy low SHALL be ignored.
REQ-021 SHALL support push and pop in same cycle, including when buffer full (count unchanged).
REQ-022 SHALL never overflow buffer: credit counts buffered plus outstanding; rvalid with outstanding=0 is a protocol error (assertion).
REQ-023 SHALL on ifu_flush_i: PC <= {ifu_flush_addr_i[XLEN-1:2],2'b00}, buffer emptied, rdy low next cycle, imem_req_o low that cycle (abandoning ungranted request).
REQ-024 SHALL on flush load discard counter with outstanding (including a gnt in the flush cycle); following rvalids decrement it and are dropped, not buffered.
REQ-025 SHALL issue post-flush requests while discards pending (credit counts them); only non-discarded responses are written.
REQ-026 SHALL give flush priority over ack, push and gnt-driven PC increment in the same cycle.
REQ-027 SHALL, with zero-wait memory (gnt same cycle, rvalid next), assert rdy two cycles after first granted request and sustain one insn/cycle for DEPTH>=3.

Reset
REQ-028 SHALL on rst_ni low asynchronously set PC=RESET_ADDR, buffer empty, outstanding=0, discard=0.
REQ-029 SHALL hold imem_req_o=0, rdy=0, insn=0, addr=0 during reset; first request in first cycle after release.
REQ-030 SHALL abandon in-flight transactions across reset; memory side is reset together.

Structure
REQ-031 SHALL take XLEN, RESET_ADDR, and sbuf entry struct {insn, addr} from shared package rv0_core_pkg.
REQ-032 SHALL instantiate one sub-module rv0_fifo (synchronous FIFO, flush/clear input) for the instruction buffer; address queue may reuse it.

Verification
REQ-033 Reset release, zero-wait mem, ack tied high -> insn/addr sequence 0x0,0x4,0x8,... one per cycle after 2-cycle latency.
REQ-034 ack held low, DEPTH=4 -> exactly 4 grants, req drops, rdy high with addr 0x0 stable; release ack -> resumes with 0x10.
REQ-035 gnt withheld 5 cycles -> imem_addr_o constant, no PC advance, no extra request.
REQ-036 Flush to 0x8000_0002 with 2 outstanding -> next request addr 0x8000_0000, both old rvalids dropped, first rdy addr 0x8000_0000.
REQ-037 Flush coinciding with ack and gnt -> no stale entry delivered, granted request counted as discard.
REQ-038 PC at 0xFFFF_FFFC -> next fetch 0x0000_0000; async reset mid-burst -> outputs zero immediately, refetch from RESET_ADDR.
